// File: rtl/mult_seq_arbiter.sv
// Round-robin arbiter and sequencer for a shared shift-add multiplier datapath.
// Optional zero-operand fast path: define MULT_ZERO_SKIP_EN.
module mult_seq_arbiter #(
  parameter int WIDTH = 3,
  parameter int CNT_W = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req0,
  input  logic [WIDTH-1:0]     m0,
  input  logic [2*WIDTH-1:0]   M0,
  input  logic                 req1,
  input  logic [WIDTH-1:0]     m1,
  input  logic [2*WIDTH-1:0]   M1,
  output logic                 ack0,
  output logic                 ack1,
  output logic [2*WIDTH-1:0]   res,
  output logic                 busy,
  output logic [WIDTH-1:0]     m,
  output logic [2*WIDTH-1:0]   M,
  output logic                 s1,
  output logic                 s2,
  output logic                 en1,
  output logic                 en2,
  input  logic                 ProxBit_m,
  input  logic [CNT_W-1:0]     CountOut,
  input  logic [2*WIDTH-1:0]   R
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, EXEC, DONE} state_e;

  state_e               state_q, state_d;
  logic                 grant_q, grant_d;
  logic                 last_grant_q, last_grant_d;
  logic [2*WIDTH-1:0]   res_q, res_d;
  logic                 win;

  // With both requesting, the one not served last wins; otherwise whoever asks.
  assign win = (req0 && req1) ? ~last_grant_q : req1;

`ifdef MULT_ZERO_SKIP_EN
  logic skip_q, skip_d;
  logic [WIDTH-1:0]   win_m;
  logic [2*WIDTH-1:0] win_M;

  assign win_m = win ? m1 : m0;
  assign win_M = win ? M1 : M0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      res_q        <= '0;
`ifdef MULT_ZERO_SKIP_EN
      skip_q       <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values together.
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      res_q        <= res_d;
`ifdef MULT_ZERO_SKIP_EN
      skip_q       <= skip_d;
`endif
    end
  end

  always_comb begin
    // NOTE: defaults first so no path through the case leaves a latch behind.
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    res_d        = res_q;
`ifdef MULT_ZERO_SKIP_EN
    skip_d       = skip_q;
`endif
    s1   = 1'b0;
    s2   = 1'b0;
    en1  = 1'b0;
    en2  = 1'b0;
    ack0 = 1'b0;
    ack1 = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          grant_d = win;
          state_d = LOAD;
`ifdef MULT_ZERO_SKIP_EN
          skip_d = (win_m == '0) || (win_M == '0);
          if (skip_d) state_d = DONE;
`endif
        end
      end
      LOAD: begin
        en1     = 1'b1;
        en2     = 1'b1;
        state_d = EXEC;
      end
      EXEC: begin
        en1 = ProxBit_m;
        s1  = 1'b1;
        en2 = 1'b1;
        s2  = 1'b1;
        if (CountOut == LAST_CNT) state_d = DONE;
      end
      DONE: begin
        ack0         = ~grant_q;
        ack1         = grant_q;
        last_grant_d = grant_q;
        state_d      = IDLE;
`ifdef MULT_ZERO_SKIP_EN
        res_d  = skip_q ? '0 : R;
        skip_d = 1'b0;
`else
        res_d  = R;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);
  assign res  = res_q;
  assign m    = (state_q == IDLE) ? '0 : (grant_q ? m1 : m0);
  assign M    = (state_q == IDLE) ? '0 : (grant_q ? M1 : M0);

endmodule

// File: tb/tb_mult_seq_arbiter.sv
// Directed bench for mult_seq_arbiter with a behavioural shift-add datapath.
module tb_mult_seq_arbiter;

  localparam int WIDTH = 3;
  localparam int CNT_W = 2;

  logic clk = 1'b0;
  logic reset;
  logic req0, req1;
  logic [WIDTH-1:0]   m0, m1;
  logic [2*WIDTH-1:0] M0, M1;
  logic ack0, ack1, busy, s1, s2, en1, en2;
  logic [2*WIDTH-1:0] res, dp_M;
  logic [WIDTH-1:0]   dp_m;
  logic               prox_bit;
  logic [CNT_W-1:0]   count_out;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   m_reg;

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] en1_hist;
  logic        en_any;

  always #5 clk = ~clk;

  mult_seq_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .m0(m0), .M0(M0),
    .req1(req1), .m1(m1), .M1(M1),
    .ack0(ack0), .ack1(ack1), .res(res), .busy(busy),
    .m(dp_m), .M(dp_M), .s1(s1), .s2(s2), .en1(en1), .en2(en2),
    .ProxBit_m(prox_bit), .CountOut(count_out), .R(r_acc)
  );

  // Shift-add datapath the controller sequences.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_reg     <= '0;
      count_out <= '0;
      r_acc     <= '0;
    end else begin
      if (en2) begin
        if (!s2) begin
          m_reg     <= dp_m;
          count_out <= '0;
        end else begin
          m_reg     <= m_reg >> 1;
          count_out <= count_out + 1'b1;
        end
      end
      if (en1) r_acc <= s1 ? r_acc + (dp_M << count_out) : '0;
    end
  end
  assign prox_bit = m_reg[0];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Waits for an ack, then checks latency, which ack, and res one cycle later.
  task automatic wait_ack(input string tag, input logic [1:0] exp_ack, input int exp_lat,
                          input logic [5:0] exp_res, input bit drop);
    int  k;
    int  idle_seen;
    bit  seen;
    k = 0; idle_seen = 0; seen = 1'b0;
    en1_hist = '0; en_any = 1'b0;
    while (!seen && k < 15) begin
      @(posedge clk); #1;
      k++;
      en1_hist[k] = en1;
      en_any = en_any | en1 | en2;
      if (!busy) idle_seen++;
      if (ack0 || ack1) seen = 1'b1;
    end
    check({tag, "_ack_seen"}, 32'(seen), 32'd1);
    check({tag, "_latency"}, 32'(k), 32'(exp_lat));
    check({tag, "_ack_id"}, 32'({ack1, ack0}), 32'(exp_ack));
    check({tag, "_no_idle"}, 32'(idle_seen), 32'd0);
    if (drop) begin
      if (exp_ack[0]) req0 = 1'b0;
      if (exp_ack[1]) req1 = 1'b0;
    end
    @(posedge clk); #1;
    check({tag, "_res"}, 32'(res), 32'(exp_res));
    check({tag, "_idle_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    m0 = '0; M0 = '0; m1 = '0; M1 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_acks", 32'({ack1, ack0}), 32'd0);
    check("rst_res", 32'(res), 32'd0);
    check("rst_ctrl", 32'({s1, s2, en1, en2}), 32'd0);
    check("rst_mM", 32'({dp_m, dp_M}), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Single op 5*3; m=101 enables accumulate in EXEC cycles 1 and 3.
    m0 = 3'd5; M0 = 6'd3; req0 = 1'b1;
    wait_ack("single", 2'b01, 5, 6'd15, 1'b1);
    check("single_en1_exec", 32'(en1_hist[4:2]), 32'b101);
    check("single_en1_load", 32'(en1_hist[1]), 32'd1);

    // Maximum operands on requester 1.
    m1 = 3'd7; M1 = 6'd7; req1 = 1'b1;
    wait_ack("max", 2'b10, 5, 6'd49, 1'b1);

    // Contention right after reset: req0 wins first.
    reset = 1'b0; #1; reset = 1'b1;
    @(posedge clk); #1;
    m0 = 3'd2; M0 = 6'd3; m1 = 3'd3; M1 = 6'd3;
    req0 = 1'b1; req1 = 1'b1;
    wait_ack("cont0", 2'b01, 5, 6'd6, 1'b1);
    wait_ack("cont1", 2'b10, 5, 6'd9, 1'b1);

    // Fairness with both held continuously.
    req0 = 1'b1; req1 = 1'b1;
    wait_ack("fair0", 2'b01, 5, 6'd6, 1'b0);
    wait_ack("fair1", 2'b10, 5, 6'd9, 1'b0);
    wait_ack("fair2", 2'b01, 5, 6'd6, 1'b0);
    wait_ack("fair3", 2'b10, 5, 6'd9, 1'b0);
    req0 = 1'b0; req1 = 1'b0;
    @(posedge clk); #1;

    // Reset in the second EXEC cycle aborts without ack.
    m0 = 3'd3; M0 = 6'd5; req0 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("midop_pre_busy", 32'(busy), 32'd1);
    check("midop_pre_en1", 32'(en1), 32'd1);
    reset = 1'b0;
    #1;
    check("midop_busy", 32'(busy), 32'd0);
    check("midop_ctrl", 32'({s1, s2, en1, en2}), 32'd0);
    check("midop_mM", 32'({dp_m, dp_M}), 32'd0);
    check("midop_acks", 32'({ack1, ack0}), 32'd0);
    check("midop_res", 32'(res), 32'd0);
    req0 = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      check("midop_hold_acks", 32'({ack1, ack0}), 32'd0);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    m0 = 3'd4; M0 = 6'd5; req0 = 1'b1;
    wait_ack("rereq", 2'b01, 5, 6'd20, 1'b1);

    // Zero multiplier.
    m0 = 3'd0; M0 = 6'd7; req0 = 1'b1;
`ifdef MULT_ZERO_SKIP_EN
    wait_ack("zero", 2'b01, 1, 6'd0, 1'b1);
    check("zero_no_en", 32'(en_any), 32'd0);
`else
    wait_ack("zero", 2'b01, 5, 6'd0, 1'b1);
    check("zero_en_used", 32'(en_any), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
